drop_scheduler: RTL and testbench
=================================

Name: drop_scheduler

Overview:
- Sequences the four lane droppers for one song. Steps through a note chart, issues one-frame launch pulses to the lanes, and accumulates score and combo from the lanes' hit/miss pulses.
- Sits between the keyboard decode (keycode) and the four per-lane dropper instances.
- Owns the game-level states idle / playing / finished, so droppers only react to launch.

Parameters:
- CHART_DEPTH, 64, number of chart entries; address width = $clog2(CHART_DEPTH).
- HIT_PTS, 10, points added per lane hit.
- KEY_START, 8'h2C, keycode that starts a song (space).
- KEY_ABORT, 8'h01, keycode that returns to idle from any state.

Ports:
- frame_clk  in  1  frame-rate clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  current primary keycode.
- lane_busy  in  4  bit i high while lane i has a note in flight.
- lane_hit  in  4  bit i: one-frame pulse, lane i note scored.
- lane_miss  in  4  bit i: one-frame pulse, lane i note reached bottom unscored.
- launch  out  4  one-frame pulse, bit i starts a note on lane i.
- score  out  16  accumulated points, saturating.
- combo  out  8  current consecutive-hit count, saturating.
- max_combo  out  8  highest combo this song.
- playing  out  1  high in FETCH/LATCH/WAIT/ISSUE/DRAIN.
- song_done  out  1  high in DONE.

Behaviour:
- Reset values: state=IDLE, launch=0, score=0, combo=0, max_combo=0, addr=0, gap_cnt=0, playing=0, song_done=0.
- Chart entry is 16 bits: [15:12] lane mask, [11:0] gap in frames before launch. Entry 16'h0000 is the end marker.
- The ROM has 1-frame synchronous read latency.
- States: IDLE, FETCH, LATCH, WAIT, ISSUE, DRAIN, DONE.
- IDLE: keycode==KEY_START -> FETCH; addr, score, combo and max_combo clear on that transition.
- FETCH: ROM address presented. Next frame -> LATCH.
- LATCH: entry registered.
  - End marker -> DRAIN.
  - Gap==0 -> ISSUE.
  - Otherwise gap_cnt=gap -> WAIT.
- WAIT: gap_cnt decrements once per frame. When the decrement reaches 0 -> ISSUE, so the launch fires exactly gap+1 frames after LATCH.
- ISSUE:
  - If (mask & lane_busy)==0: launch=mask for exactly one frame, then addr+1 and -> FETCH.
  - Otherwise stall in ISSUE with launch=0 until the lanes are free. There is no timeout.
  - Mask 0 with gap!=0 is a rest: no launch pulse, advance.
  - If addr==CHART_DEPTH-1 when advancing, -> DRAIN instead of FETCH; addr never wraps.
- DRAIN: lane_busy==0 -> DONE.
- DONE: song_done=1; holds score, combo and max_combo.
- Abort: keycode==KEY_ABORT in any state other than IDLE -> IDLE next frame.
  - launch is forced 0 that frame.
  - score, combo and max_combo are held until the next start.
- Start key while not IDLE is ignored. Abort has priority over start and over every other transition.
- Scoring is evaluated every frame in every state except IDLE:
  - score += popcount(lane_hit)*HIT_PTS, saturating at 16'hFFFF.
  - Any lane_miss bit set -> combo=0 that frame. Miss wins over simultaneous hits, but those hits still add score.
  - Otherwise combo += popcount(lane_hit), saturating at 255.
  - max_combo = max(max_combo, new combo), updated the same frame.
- Hit/miss pulses in IDLE are ignored.
- Reset mid-song: everything returns to reset values next frame, and launch is 0.

Decomposition:
- Package rhythm_pkg holds:
  - state enum sched_state_t;
  - chart_entry_t struct {lane_mask[3:0], gap[11:0]};
  - constants KEY_START, KEY_ABORT, KEY_LEFT/DOWN/UP/RIGHT, LANE_COUNT=4.
- Sub-module note_chart_rom (address in, chart_entry_t out, registered, initialised from a chart file).
- Popcount is a package function.

Test Plan:
- Chart {0x1005, 0x2000, 0x0000}, lane_busy=0, start key -> launch=4'b0001 exactly 6 frames after LATCH, then 4'b0010 three frames later (FETCH, LATCH, ISSUE), then DRAIN -> DONE, song_done=1.
- Chart {0x3000}, lane_busy=4'b0010 held 10 frames -> launch stays 0 for 10 frames, then pulses 4'b0011 once.
- lane_hit=4'b0101 in one frame, then 4'b0001 -> score=30, combo=3, max_combo=3. Next frame lane_hit=4'b0010 with lane_miss=4'b1000 -> score=40, combo=0, max_combo=3.
- Abort keycode 8'h01 during WAIT with gap_cnt=100 -> IDLE next frame, no launch issued, score held. Start key -> score=0, addr=0.
- CHART_DEPTH=4 with no end marker -> exactly 4 launches, then DRAIN, and addr never wraps to 0.
- Reset asserted the same frame as an ISSUE launch -> launch=0 next frame, state=IDLE, all counters 0.

Source files
------------

// File: rtl/rhythm_pkg.sv
// Shared types, keycodes and helpers for the song scheduler and its chart ROM.
package rhythm_pkg;

    localparam int unsigned LANE_COUNT      = 4;
    localparam int unsigned CHART_DEPTH_DEF = 64;
    localparam int unsigned HIT_PTS_DEF     = 10;

    localparam logic [7:0] KEY_START = 8'h2C;
    localparam logic [7:0] KEY_ABORT = 8'h01;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_DOWN  = 8'h51;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    typedef struct packed {
        logic [3:0]  lane_mask;
        logic [11:0] gap;
    } chart_entry_t;

    // An all-zero entry terminates the chart.
    localparam chart_entry_t CHART_END = '0;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/note_chart_rom.sv
// Note chart storage. IMAGE is the chart file flattened into one vector,
// entry i at bits [16*i +: 16]. Reads are registered (one frame latency).
module note_chart_rom
    import rhythm_pkg::*;
#(
    parameter int unsigned           DEPTH = 64,
    parameter int unsigned           AW    = $clog2(DEPTH),
    parameter logic [DEPTH*16-1:0]   IMAGE = '0
) (
    input  logic          frame_clk,
    input  logic [AW-1:0] addr_i,
    output chart_entry_t  entry_o
);

    chart_entry_t mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign mem[i] = IMAGE[i*16 +: 16];
    end

    // Synchronous read port
    always_ff @(posedge frame_clk) begin
        entry_o <= mem[addr_i];
    end

endmodule

// File: rtl/drop_scheduler.sv
// Song sequencer: walks the note chart, pulses lane launches and keeps score.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no song; waits for the start key
//   FETCH  | chart address presented to the ROM
//   LATCH  | ROM entry valid; decide end / immediate issue / wait
//   WAIT   | counting down the gap before the launch
//   ISSUE  | launch once the target lanes are free, then advance
//   DRAIN  | chart exhausted; wait for notes in flight to land
//   DONE   | song finished; results held until abort
module drop_scheduler #(
    parameter int unsigned               CHART_DEPTH = rhythm_pkg::CHART_DEPTH_DEF,
    parameter int unsigned               HIT_PTS     = rhythm_pkg::HIT_PTS_DEF,
    parameter logic [7:0]                KEY_START   = rhythm_pkg::KEY_START,
    parameter logic [7:0]                KEY_ABORT   = rhythm_pkg::KEY_ABORT,
    parameter logic [CHART_DEPTH*16-1:0] CHART_IMAGE = '0
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [7:0]  keycode,
    input  logic [3:0]  lane_busy,
    input  logic [3:0]  lane_hit,
    input  logic [3:0]  lane_miss,
    output logic [3:0]  launch,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo,
    output logic        playing,
    output logic        song_done
);
    import rhythm_pkg::*;

    localparam int unsigned AW = $clog2(CHART_DEPTH);

    sched_state_t  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [11:0]   gap_cnt_q, gap_cnt_d;
    logic [3:0]    mask_q, mask_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    combo_q, combo_d;
    logic [7:0]    max_combo_q, max_combo_d;

    chart_entry_t  rom_entry;
    logic          abort, start_song, lanes_free;
    logic [2:0]    hit_cnt;
    logic [31:0]   score_sum;
    logic [8:0]    combo_sum;

    note_chart_rom #(
        .DEPTH (CHART_DEPTH),
        .AW    (AW),
        .IMAGE (CHART_IMAGE)
    ) u_rom (
        .frame_clk (frame_clk),
        .addr_i    (addr_q),
        .entry_o   (rom_entry)
    );

    assign abort      = (state_q != S_IDLE) && (keycode == KEY_ABORT);
    assign start_song = (state_q == S_IDLE) && (keycode == KEY_START);
    assign lanes_free = (mask_q & lane_busy) == 4'b0000;

    assign hit_cnt   = popcount4(lane_hit);
    assign score_sum = 32'(score_q) + 32'(hit_cnt) * HIT_PTS;
    assign combo_sum = 9'(combo_q) + 9'(hit_cnt);

    // State and datapath registers
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            gap_cnt_q   <= '0;
            mask_q      <= '0;
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            gap_cnt_q   <= gap_cnt_d;
            mask_q      <= mask_d;
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
        end
    end

    // Next-state and chart walk; abort overrides every other transition
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        gap_cnt_d = gap_cnt_q;
        mask_d    = mask_q;
        case (state_q)
            S_IDLE: begin
                if (keycode == KEY_START) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                mask_d = rom_entry.lane_mask;
                if (rom_entry == CHART_END) begin
                    state_d = S_DRAIN;
                end else if (rom_entry.gap == 12'd0) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = rom_entry.gap;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                gap_cnt_d = gap_cnt_q - 12'd1;
                if (gap_cnt_q == 12'd1) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                // addr saturates at the last entry so a chart without an
                // end marker drains instead of replaying from the top
                if (lanes_free) begin
                    if (addr_q == AW'(CHART_DEPTH - 1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DRAIN: begin
                if (lane_busy == 4'b0000) state_d = S_DONE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // Moore status flags plus the launch pulse gated by lane availability
    always_comb begin
        launch    = 4'b0000;
        playing   = 1'b0;
        song_done = 1'b0;
        if (state_q == S_ISSUE && lanes_free && !abort) launch = mask_q;
        playing   = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                    (state_q == S_WAIT)  || (state_q == S_ISSUE) ||
                    (state_q == S_DRAIN);
        song_done = (state_q == S_DONE);
    end

    // Score and combo; a miss clears the combo but simultaneous hits still score
    always_comb begin
        score_d     = score_q;
        combo_d     = combo_q;
        max_combo_d = max_combo_q;
        if (start_song) begin
            score_d     = '0;
            combo_d     = '0;
            max_combo_d = '0;
        end else if (state_q != S_IDLE) begin
            score_d = (score_sum > 32'h0000_FFFF) ? 16'hFFFF : score_sum[15:0];
            if (lane_miss != 4'b0000) combo_d = '0;
            else                      combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
            if (combo_d > max_combo_q) max_combo_d = combo_d;
        end
    end

    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = max_combo_q;

endmodule

// File: tb/tb_drop_scheduler.sv
// Bench for drop_scheduler: two instances (64-entry chart with end marker,
// 4-entry chart without one) checked every frame against a frame-count model.
`timescale 1ns/1ps
module tb_drop_scheduler;

    localparam logic [7:0] K_START = 8'h2C;
    localparam logic [7:0] K_ABORT = 8'h01;
    localparam int DEP_A = 64;
    localparam int DEP_B = 4;
    localparam logic [DEP_A*16-1:0] IMG_A = {976'd0, 16'h0000, 16'h2000, 16'h1005};
    localparam logic [DEP_B*16-1:0] IMG_B = {16'h8000, 16'h1002, 16'h4064, 16'h3000};
    localparam int M_OFF = 0, M_SONG = 1, M_DRAIN = 2, M_DONE = 3;

    typedef struct {
        int mode;
        int idx;
        int fetch_at;
        int score;
        int combo;
        int maxc;
    } mdl_t;

    logic        frame_clk = 1'b0;
    logic        rst;
    logic [7:0]  kc     [2];
    logic [3:0]  busy   [2];
    logic [3:0]  hit    [2];
    logic [3:0]  miss   [2];
    logic [3:0]  launch [2];
    logic [15:0] score  [2];
    logic [7:0]  combo  [2];
    logic [7:0]  maxc   [2];
    logic        playing[2];
    logic        done   [2];

    logic [DEP_A*16-1:0] img_a;
    logic [DEP_B*16-1:0] img_b;
    mdl_t mdl [2];
    int   frame_no = 0;
    bit   chk_on   = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 frame_clk = ~frame_clk;

    drop_scheduler #(.CHART_DEPTH(DEP_A), .HIT_PTS(10), .CHART_IMAGE(IMG_A)) dut_a (
        .frame_clk(frame_clk), .Reset(rst), .keycode(kc[0]), .lane_busy(busy[0]),
        .lane_hit(hit[0]), .lane_miss(miss[0]), .launch(launch[0]), .score(score[0]),
        .combo(combo[0]), .max_combo(maxc[0]), .playing(playing[0]), .song_done(done[0]));

    drop_scheduler #(.CHART_DEPTH(DEP_B), .HIT_PTS(1000), .CHART_IMAGE(IMG_B)) dut_b (
        .frame_clk(frame_clk), .Reset(rst), .keycode(kc[1]), .lane_busy(busy[1]),
        .lane_hit(hit[1]), .lane_miss(miss[1]), .launch(launch[1]), .score(score[1]),
        .combo(combo[1]), .max_combo(maxc[1]), .playing(playing[1]), .song_done(done[1]));

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] chart_at(input int d, input int idx);
        if (d == 0) return img_a[idx*16 +: 16];
        return img_b[idx*16 +: 16];
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? DEP_A : DEP_B;
    endfunction

    function automatic int pts(input int d);
        return (d == 0) ? 10 : 1000;
    endfunction

    // An entry fetched at frame F is latched at F+1 and may issue from F+2+gap.
    function automatic bit issue_now(input mdl_t m, input int d, input int t);
        logic [15:0] e;
        if (m.mode != M_SONG) return 1'b0;
        e = chart_at(d, m.idx);
        if (e == 16'h0000) return 1'b0;
        if (t < m.fetch_at + 2 + int'(e[11:0])) return 1'b0;
        return (e[15:12] & busy[d]) == 4'b0000;
    endfunction

    function automatic logic [3:0] exp_launch(input mdl_t m, input int d, input int t);
        logic [15:0] e;
        if (kc[d] == K_ABORT || !issue_now(m, d, t)) return 4'b0000;
        e = chart_at(d, m.idx);
        return e[15:12];
    endfunction

    function automatic mdl_t model_next(input mdl_t m, input int d, input int t);
        mdl_t n;
        int h;
        logic [15:0] e;
        n = m;
        if (rst) begin
            n = '{M_OFF, 0, 0, 0, 0, 0};
            return n;
        end
        h = $countones(hit[d]);
        if (m.mode != M_OFF) begin
            n.score = (m.score + h * pts(d) > 65535) ? 65535 : m.score + h * pts(d);
            if (miss[d] != 4'b0000) n.combo = 0;
            else n.combo = (m.combo + h > 255) ? 255 : m.combo + h;
            if (n.combo > m.maxc) n.maxc = n.combo;
            if (kc[d] == K_ABORT) begin
                n.mode = M_OFF;
                return n;
            end
        end
        case (m.mode)
            M_OFF: if (kc[d] == K_START) n = '{M_SONG, 0, t + 1, 0, 0, 0};
            M_SONG: begin
                e = chart_at(d, m.idx);
                if (e == 16'h0000) begin
                    if (t == m.fetch_at + 1) n.mode = M_DRAIN;
                end else if (issue_now(m, d, t)) begin
                    if (m.idx == depth(d) - 1) n.mode = M_DRAIN;
                    else begin
                        n.idx      = m.idx + 1;
                        n.fetch_at = t + 1;
                    end
                end
            end
            M_DRAIN: if (busy[d] == 4'b0000) n.mode = M_DONE;
            default: ;
        endcase
        return n;
    endfunction

    // Per-frame comparison of both instances against the model, then model step
    always @(negedge frame_clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("launch%0d", d), int'(launch[d]), int'(exp_launch(mdl[d], d, frame_no)));
                check($sformatf("score%0d", d), int'(score[d]), mdl[d].score);
                check($sformatf("combo%0d", d), int'(combo[d]), mdl[d].combo);
                check($sformatf("max_combo%0d", d), int'(maxc[d]), mdl[d].maxc);
                check($sformatf("playing%0d", d), int'(playing[d]),
                      int'(mdl[d].mode == M_SONG || mdl[d].mode == M_DRAIN));
                check($sformatf("song_done%0d", d), int'(done[d]), int'(mdl[d].mode == M_DONE));
            end
        end
        for (int d = 0; d < 2; d++) mdl[d] <= model_next(mdl[d], d, frame_no);
        frame_no <= frame_no + 1;
    end

    task automatic next_frame();
        @(posedge frame_clk);
        #1;
    endtask

    initial begin
        int r;
        int n_launch;
        img_a  = IMG_A;
        img_b  = IMG_B;
        mdl[0] = '{M_OFF, 0, 0, 0, 0, 0};
        mdl[1] = '{M_OFF, 0, 0, 0, 0, 0};
        rst    = 1'b1;
        for (int d = 0; d < 2; d++) begin
            kc[d] = 8'h00; busy[d] = 4'b0; hit[d] = 4'b0; miss[d] = 4'b0;
        end
        next_frame();
        chk_on = 1'b1;
        next_frame();
        check("rst_launch", int'(launch[0]), 0);
        check("rst_score", int'(score[0]), 0);
        check("rst_playing", int'(playing[0]), 0);
        check("rst_done", int'(done[0]), 0);
        rst = 1'b0;

        // Chart {1005, 2000, end}: launches at LATCH+6 and 3 frames later
        next_frame();
        kc[0] = K_START;
        for (int k = 1; k <= 16; k++) begin
            next_frame();
            kc[0] = 8'h00;
            #1;
            if (k == 8)       check("a_launch_lane0", int'(launch[0]), 4'b0001);
            else if (k == 11) check("a_launch_lane1", int'(launch[0]), 4'b0010);
            else              check("a_quiet", int'(launch[0]), 0);
            if (k == 14) check("a_drain_playing", int'(playing[0]), 1);
            if (k == 15) check("a_song_done", int'(done[0]), 1);
        end

        // Scoring: hits ignored in IDLE, then 0101,0001, then hit+miss
        kc[0] = K_ABORT;
        next_frame();
        kc[0] = 8'h00; hit[0] = 4'b1111;
        next_frame();
        hit[0] = 4'b0000; kc[0] = K_START;
        next_frame();
        kc[0] = 8'h00; hit[0] = 4'b0101;
        next_frame();
        hit[0] = 4'b0001;
        next_frame();
        hit[0] = 4'b0010; miss[0] = 4'b1000;
        #1;
        check("s_score30", int'(score[0]), 30);
        check("s_combo3", int'(combo[0]), 3);
        check("s_max3", int'(maxc[0]), 3);
        next_frame();
        hit[0] = 4'b0000; miss[0] = 4'b0000;
        #1;
        check("s_score40", int'(score[0]), 40);
        check("s_combo0", int'(combo[0]), 0);
        check("s_max_held", int'(maxc[0]), 3);
        repeat (20) next_frame();

        // Depth-4 chart: busy stall, hit, then abort during the 100-frame gap
        kc[1] = K_START;
        for (int k = 1; k <= 31; k++) begin
            next_frame();
            kc[1]   = (k == 30) ? K_ABORT : 8'h00;
            busy[1] = (k >= 3 && k <= 12) ? 4'b0010 : 4'b0000;
            hit[1]  = (k == 20) ? 4'b0011 : 4'b0000;
            #1;
            if (k >= 3 && k <= 12) check("b_stall", int'(launch[1]), 0);
            if (k == 13) check("b_release", int'(launch[1]), 4'b0011);
            if (k == 21) check("b_score", int'(score[1]), 2000);
            if (k == 30) check("b_abort_nolaunch", int'(launch[1]), 0);
            if (k == 31) begin
                check("b_abort_idle", int'(playing[1]), 0);
                check("b_abort_score_held", int'(score[1]), 2000);
            end
        end
        repeat (3) next_frame();

        // Restart: stats clear, addr back to 0, 4 launches then no wrap
        kc[1] = K_START;
        n_launch = 0;
        for (int k = 1; k <= 130; k++) begin
            next_frame();
            kc[1]  = 8'h00;
            hit[1] = (k >= 10 && k <= 90) ? 4'b1111 : 4'b0000;
            #1;
            if (launch[1] != 4'b0000) n_launch++;
            if (k == 1)   check("r_score_clear", int'(score[1]), 0);
            if (k == 3)   check("r_first_entry", int'(launch[1]), 4'b0011);
            if (k == 91) begin
                check("r_score_sat", int'(score[1]), 65535);
                check("r_combo_sat", int'(combo[1]), 255);
                check("r_max_sat", int'(maxc[1]), 255);
            end
            if (k == 106) check("r_gap100", int'(launch[1]), 4'b0100);
            if (k == 114) check("r_last", int'(launch[1]), 4'b1000);
            if (k == 116) check("r_done", int'(done[1]), 1);
        end
        check("r_launch_count", n_launch, 4);

        // Reset on the launch frame of dut_a
        kc[0] = K_ABORT;
        next_frame();
        kc[0] = K_START;
        for (int k = 1; k <= 9; k++) begin
            next_frame();
            kc[0]  = 8'h00;
            rst    = (k == 8);
            hit[0] = (k == 2) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 8) begin
                check("x_launch_before", int'(launch[0]), 4'b0001);
                check("x_score_before", int'(score[0]), 10);
            end
            if (k == 9) begin
                check("x_launch_after", int'(launch[0]), 0);
                check("x_idle_after", int'(playing[0]), 0);
                check("x_score_after", int'(score[0]), 0);
                check("x_combo_after", int'(combo[0]), 0);
            end
        end
        rst = 1'b0;

        // Randomized play on both instances
        for (int k = 0; k < 3000; k++) begin
            next_frame();
            rst = ($urandom_range(0, 499) == 0);
            for (int d = 0; d < 2; d++) begin
                r = $urandom_range(0, 199);
                if (mdl[d].mode == M_DONE && r < 20) kc[d] = K_ABORT;
                else if (r == 0)                    kc[d] = K_ABORT;
                else if (r < 8)                     kc[d] = K_START;
                else if (r < 12)                    kc[d] = 8'h50;
                else                                kc[d] = 8'h00;
                busy[d] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                if (mdl[d].mode != M_DONE) begin
                    hit[d]  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
                    miss[d] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
                end else begin
                    hit[d]  = 4'b0000;
                    miss[d] = 4'b0000;
                end
            end
        end
        next_frame();
        next_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
